// File: rtl/gate_sweep_pkg.sv
// Shared encodings and sizes for the gate sweep checker.
// The FSM state values are fixed so they can be probed by number on a scope.
package gate_sweep_pkg;
  localparam int MINTERMS = 4;
  localparam int MT_W     = 2;
  localparam int ERR_W    = 3;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t DRIVE  = 2'd1;
  localparam state_t SAMPLE = 2'd2;
  localparam state_t DONE   = 2'd3;
endpackage

// File: rtl/gate_sweep_checker_if.sv
// Interface bundle for the gate sweep checker.
// It carries the start/done handshake, the result and the gate-under-test pins.
interface gate_sweep_checker_if;
  import gate_sweep_pkg::*;

  logic                start;
  logic                gate_s;
  logic                x;
  logic                y;
  logic                busy;
  logic                done;
  logic [MINTERMS-1:0] table_o;
  logic [ERR_W-1:0]    err_cnt;
  logic                pass;

  modport master (output start, gate_s,
                  input  x, y, busy, done, table_o, err_cnt, pass);
  modport slave  (input  start, gate_s,
                  output x, y, busy, done, table_o, err_cnt, pass);
endinterface

// File: rtl/gate_sweep_checker_settle_timer.sv
// Loadable 4-bit down-counter that times how long each minterm is held.
// The expire output goes high on the last counting cycle, so a load of N gives N cycles.
module settle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       en,
  input  logic [3:0] load_val,
  output logic       expire
);
  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (en && (cnt != 4'd0))
      cnt <= cnt - 4'd1;
  end

  assign expire = en && (cnt == 4'd1);
endmodule

// File: rtl/gate_sweep_checker.sv
// Sweeps a two-input gate under test through minterms 0..3 and compares it with EXPECT.
// Define GATE_SWEEP_STOP_ON_ERR_EN to end the sweep at the first mismatching minterm.
module gate_sweep_checker
  import gate_sweep_pkg::*;
#(
  parameter logic [MINTERMS-1:0] EXPECT = 4'b0001,
  parameter int                  SETTLE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  gate_sweep_checker_if.slave bus
);
  state_t              state;
  state_t              next_state;
  logic [MT_W-1:0]     m;
  logic [MINTERMS-1:0] tbl;
  logic [ERR_W-1:0]    err;
  logic [ERR_W-1:0]    err_nxt;
  logic                pass_r;
  logic                mismatch;
  logic                last_mt;
  logic                stop;
  logic                tmr_load;
  logic                tmr_en;
  logic                tmr_expire;

  assign mismatch = (bus.gate_s != EXPECT[m]);
  assign last_mt  = (m == MT_W'(MINTERMS - 1));
  assign err_nxt  = err + ERR_W'(mismatch);

`ifdef GATE_SWEEP_STOP_ON_ERR_EN
  assign stop = last_mt || mismatch;
`else
  assign stop = last_mt;
`endif

  // The timer is reloaded on every entry into DRIVE, from IDLE or from SAMPLE.
  assign tmr_load = (next_state == DRIVE) && (state != DRIVE);
  assign tmr_en   = (state == DRIVE);

  settle_timer u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (4'(SETTLE)),
    .expire   (tmr_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = DRIVE;
      DRIVE:   if (tmr_expire) next_state = SAMPLE;
      SAMPLE:  next_state = stop ? DONE : DRIVE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // gate_s is only looked at on the closing edge of SAMPLE; DRIVE glitches never land.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m      <= '0;
      tbl    <= '0;
      err    <= '0;
      pass_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            m      <= '0;
            tbl    <= '0;
            err    <= '0;
            pass_r <= 1'b0;
          end
        end
        SAMPLE: begin
          tbl[m] <= bus.gate_s;
          err    <= err_nxt;
          if (stop)
            pass_r <= (err_nxt == '0);
          else
            m <= m + MT_W'(1);
        end
        DONE:    m <= '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.busy    = (state == DRIVE) || (state == SAMPLE);
    bus.done    = (state == DONE);
    {bus.x, bus.y} = bus.busy ? m : '0;
    bus.table_o = tbl;
    bus.err_cnt = err;
    bus.pass    = pass_r;
  end
endmodule

// File: doc/gate_sweep_checker.md
Name: gate_sweep_checker

Overview:
- Sequential test stage that wraps a two-input combinational gate under test (GUT).
- Upstream side: drives the GUT inputs x,y through all four minterms in order 0..3.
- Downstream side: samples the GUT output s for each minterm and assembles the observed 4-bit truth table.
- Compares the observed table against an expected table and reports mismatch count and pass/fail through a start/done handshake.

Parameters:
- EXPECT, 4'b0001, expected GUT output per minterm; bit m = s for minterm m = {x,y}. Default is the NOR function ~x & ~y.
- SETTLE, 1, cycles each minterm is held before sampling; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a sweep; accepted only in IDLE
- gate_s  input  1  GUT output
- x  output  1  GUT input a = minterm bit 1
- y  output  1  GUT input b = minterm bit 0
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse at sweep end
- table_o  output  4  observed truth table; bit m = sampled gate_s
- err_cnt  output  3  number of minterms where table_o[m] != EXPECT[m] (0..4)
- pass  output  1  valid when done; held until next accepted start

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n=0, takes effect immediately, no clock edge needed): state IDLE; x=y=0; busy=done=pass=0; table_o=0; err_cnt=0; minterm m=0; settle count=0.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - start=1 at a clock edge -> DRIVE with m=0.
  - At the same edge, table_o, err_cnt and pass are cleared.
- DRIVE:
  - {x,y}=m held stable; busy=1.
  - Stays exactly SETTLE cycles, then -> SAMPLE.
- SAMPLE:
  - One cycle.
  - At its closing edge: table_o[m] <= gate_s; if gate_s != EXPECT[m], err_cnt += 1.
  - If m==3 -> DONE; else m += 1 and -> DRIVE.
  - x,y are unchanged during SAMPLE.
- DONE:
  - One cycle: done=1, busy=0, pass=(err_cnt==0).
  - Then -> IDLE. x,y return to 0 in IDLE.
- Latency: start sampled at edge 0; done is high during cycle 1+4*(SETTLE+1). With SETTLE=1 that is cycle 9.
- start while busy or in DONE: ignored, not queued.
- start held high continuously: a new sweep begins on the edge after DONE (back-to-back sweeps).
- table_o, err_cnt and pass keep their final values in IDLE until the next accepted start.
- err_cnt never exceeds 4; width 3 bits, so no wrap.
- Reset mid-sweep: immediate return to reset values; the partial table is discarded; no done pulse.
- gate_s is sampled only at SAMPLE closing edges; glitches during DRIVE are ignored.

Optional Feature:
- Macro: GATE_SWEEP_STOP_ON_ERR_EN.
- Defined:
  - First mismatch in SAMPLE goes directly to DONE, with err_cnt=1 and pass=0.
  - table_o bits for minterms not yet sampled remain 0.
  - Latency is shortened accordingly.
- Undefined: all four minterms are always swept; err_cnt is the full mismatch count.

Decomposition:
- Package gate_sweep_pkg:
  - state encoding localparams (IDLE=2'd0, DRIVE=2'd1, SAMPLE=2'd2, DONE=2'd3)
  - MINTERMS=4
  - MT_W=2
  - ERR_W=3
- Sub-module settle_timer:
  - loadable down-counter (4 bits) with load/expire signals.
  - The FSM loads SETTLE on DRIVE entry and leaves DRIVE on expire.
- FSM, minterm counter and compare/accumulate logic stay in gate_sweep_checker.

Test Plan:
- Correct NOR GUT, defaults, start pulse at cycle 0 -> x,y sequence 00,01,10,11; done at cycle 9; table_o=4'b0001, err_cnt=0, pass=1.
- Faulty GUT s=~x&y, EXPECT=4'b0001 -> table_o=4'b0010, err_cnt=2, pass=0.
- SETTLE=3, correct GUT -> done at cycle 17; each {x,y} value held 4 cycles; pass=1.
- rst_n pulled low at cycle 5 (mid-sweep) -> all outputs 0 immediately, no done; a fresh start after release -> normal result, done 9 cycles later.
- start pulsed at cycles 3 and 6 during a sweep -> ignored, single done at cycle 9; start held high -> second done at cycle 19.
- GATE_SWEEP_STOP_ON_ERR_EN defined, GUT stuck-at-1 -> mismatch at minterm 1; done at cycle 5; table_o=4'b0011, err_cnt=1, pass=0.
